// File: rtl/whr_inj_ctrl.sv
// Packet injection controller for one wormhole router input channel.
// Takes a descriptor plus payload words from a client and emits explicit-length
// flits (head then body). Spends one downstream buffer credit per flit and
// regains one credit for each cycle that flow_ctrl_in is high.
module whr_inj_ctrl #(
    parameter int buffer_size          = 8,
    parameter int num_routers_per_dim  = 4,
    parameter int num_dimensions       = 2,
    parameter int num_nodes_per_router = 1,
    parameter int max_payload_length   = 4,
    parameter int min_payload_length   = 1,
    parameter int enable_link_pm       = 1,
    parameter int flow_ctrl_bypass     = 1,
    parameter int flit_data_width      = 64,
    localparam int addr_width    = num_dimensions * $clog2(num_routers_per_dim)
                                   + $clog2(num_nodes_per_router),
    localparam int len_width     = $clog2(max_payload_length + 1),
    localparam int lf_raw_width  = $clog2(max_payload_length - min_payload_length + 1),
    localparam int lf_width      = (lf_raw_width < 1) ? 1 : lf_raw_width,
    localparam int channel_width = ((enable_link_pm != 0) ? 1 : 0) + 2 + flit_data_width,
    localparam int cred_width    = $clog2(buffer_size + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [addr_width-1:0]      req_dest,
    input  logic [len_width-1:0]       req_length,
    input  logic                       data_valid,
    output logic                       data_ready,
    input  logic [flit_data_width-1:0] data_in,
    output logic [channel_width-1:0]   channel_out,
    input  logic                       flow_ctrl_in,
    output logic [cred_width-1:0]      credit_count,
    output logic                       error
);

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    localparam logic [cred_width-1:0] credits_full = cred_width'(buffer_size);

    state_t                     state_q, state_d;
    logic [cred_width-1:0]      credits_q, credits_d;
    logic [len_width-1:0]       remaining_q, remaining_d;
    logic                       link_ctrl_q, link_ctrl_d;
    logic                       flit_valid_q, flit_valid_d;
    logic                       flit_head_q, flit_head_d;
    logic [flit_data_width-1:0] flit_data_q, flit_data_d;
    logic                       error_q, error_d;

    logic                       credit_ok;
    logic                       accept_req;
    logic                       accept_data;
    logic                       launch;
    logic                       overflow;
    logic                       len_bad;
    logic [len_width-1:0]       len_clamped;
    logic [lf_width-1:0]        lf_field;
    logic [flit_data_width-1:0] head_data;

    // Handshakes, length clamping, head formatting and next-state computation
    always_comb begin
        credit_ok   = (credits_q != '0) || ((flow_ctrl_bypass != 0) && flow_ctrl_in);
        req_ready   = (state_q == IDLE) && credit_ok;
        data_ready  = (state_q == BODY) && credit_ok;
        accept_req  = req_valid && req_ready;
        accept_data = data_valid && data_ready;
        launch      = accept_req || accept_data;

        len_bad = (int'(req_length) < min_payload_length) ||
                  (int'(req_length) > max_payload_length);
        if (int'(req_length) < min_payload_length) begin
            len_clamped = len_width'(min_payload_length);
        end else if (int'(req_length) > max_payload_length) begin
            len_clamped = len_width'(max_payload_length);
        end else begin
            len_clamped = req_length;
        end
        lf_field = lf_width'(int'(len_clamped) - min_payload_length);

        head_data = '0;
        head_data[flit_data_width-1 -: addr_width]          = req_dest;
        head_data[flit_data_width-1-addr_width -: lf_width] = lf_field;

        overflow = flow_ctrl_in && !launch && (credits_q == credits_full);

        state_d     = state_q;
        remaining_d = remaining_q;
        credits_d   = credits_q;
        error_d     = error_q || overflow || (accept_req && len_bad);

        if (launch && !flow_ctrl_in) begin
            credits_d = credits_q - cred_width'(1);
        end else if (!launch && flow_ctrl_in && !overflow) begin
            credits_d = credits_q + cred_width'(1);
        end

        if (accept_req) begin
            remaining_d = len_clamped;
            state_d     = (len_clamped != '0) ? BODY : IDLE;
        end else if (accept_data) begin
            remaining_d = remaining_q - len_width'(1);
            if (remaining_q == len_width'(1)) begin
                state_d = IDLE;
            end
        end

        link_ctrl_d  = req_valid || (state_q == BODY) || launch;
        flit_valid_d = launch;
        flit_head_d  = accept_req;
        if (accept_req) begin
            flit_data_d = head_data;
        end else if (accept_data) begin
            flit_data_d = data_in;
        end else begin
            flit_data_d = flit_data_q;
        end
    end

    // State, credit counter, registered channel fields and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            credits_q    <= credits_full;
            remaining_q  <= '0;
            link_ctrl_q  <= 1'b0;
            flit_valid_q <= 1'b0;
            flit_head_q  <= 1'b0;
            flit_data_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            credits_q    <= credits_d;
            remaining_q  <= remaining_d;
            link_ctrl_q  <= link_ctrl_d;
            flit_valid_q <= flit_valid_d;
            flit_head_q  <= flit_head_d;
            flit_data_q  <= flit_data_d;
            error_q      <= error_d;
        end
    end

    generate
        if (enable_link_pm != 0) begin : g_link
            assign channel_out = {link_ctrl_q, flit_valid_q, flit_head_q, flit_data_q};
        end else begin : g_nolink
            assign channel_out = {flit_valid_q, flit_head_q, flit_data_q};
        end
    endgenerate

    assign credit_count = credits_q;
    assign error        = error_q;

endmodule
